// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: accepts a byte over valid/ready and serializes it LSB first.
// One bit lasts BAUD_DIV sclk cycles; tx_done pulses in the first idle cycle after the stop bit.
module uart_byte_tx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign tx_ready = (state == IDLE) && rst_n;

    // Frame sequencer; tx is loaded one cycle ahead so each bit starts on the state change.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shift_reg <= tx_data;
                        baud_cnt  <= '0;
                        state     <= START;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx       <= 1'b1;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at BAUD_DIV=4: table of frames plus reset and back-to-back sequences.
module tb_uart_byte_tx;

    localparam int unsigned BAUD = 4;
    localparam int unsigned FRAME_CYC = 10 * BAUD;

    logic       sclk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_cmp;
    int n_err;

    uart_byte_tx #(.BAUD_DIV(BAUD)) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // exp_bits[k] is the k-th serial bit on the line: start, d0..d7, stop
    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_bits;
        int         change_at;
        logic [7:0] change_val;
        int         pulse_at;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check($sformatf("%s tx", tag), 32'(tx), 32'd1);
        check($sformatf("%s busy", tag), 32'(tx_busy), 32'd0);
        check($sformatf("%s done", tag), 32'(tx_done), 32'd0);
        check($sformatf("%s ready", tag), 32'(tx_ready), 32'(exp_ready));
    endtask

    // Drive one byte at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_frame(input logic [7:0] d);
        @(negedge sclk);
        check($sformatf("ready before %02h", d), 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge sclk);
    endtask

    // Check 40 frame cycles starting at the current negedge, then the done cycle.
    task automatic check_frame(input string tag, input logic [9:0] exp_bits, input bit keep_valid,
                               input int change_at, input logic [7:0] change_val, input int pulse_at);
        if (!keep_valid) tx_valid = 1'b0;
        for (int i = 0; i < int'(FRAME_CYC); i++) begin
            if (i > 0) @(negedge sclk);
            check($sformatf("%s c%0d tx", tag, i), 32'(tx), 32'(exp_bits[i / int'(BAUD)]));
            check($sformatf("%s c%0d busy", tag, i), 32'(tx_busy), 32'd1);
            check($sformatf("%s c%0d ready", tag, i), 32'(tx_ready), 32'd0);
            check($sformatf("%s c%0d done", tag, i), 32'(tx_done), 32'd0);
            if (i == change_at) tx_data = change_val;
            if (i == pulse_at) begin
                tx_data  = 8'h12;
                tx_valid = 1'b1;
            end
            if (i == pulse_at + 1) tx_valid = 1'b0;
        end
        @(negedge sclk);
        check($sformatf("%s done pulse", tag), 32'(tx_done), 32'd1);
        check($sformatf("%s done tx", tag), 32'(tx), 32'd1);
        check($sformatf("%s done busy", tag), 32'(tx_busy), 32'd0);
        check($sformatf("%s done ready", tag), 32'(tx_ready), 32'd1);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        vecs[0] = '{data: 8'hA5, exp_bits: 10'b1_10100101_0, change_at: -1, change_val: 8'h00, pulse_at: -10};
        vecs[1] = '{data: 8'h3C, exp_bits: 10'b1_00111100_0, change_at: 10, change_val: 8'hC3, pulse_at: -10};
        vecs[2] = '{data: 8'h5A, exp_bits: 10'b1_01011010_0, change_at: -1, change_val: 8'h00, pulse_at: 20};

        // Reset held for 3 cycles, then 50 idle cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            check_idle($sformatf("reset c%0d", i), 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge sclk);
            check_idle($sformatf("idle c%0d", i), 1'b1);
        end

        // Table of single frames: plain, mid-frame data change, ignored valid while busy
        for (int v = 0; v < 3; v++) begin
            start_frame(vecs[v].data);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_bits, 1'b0,
                        vecs[v].change_at, vecs[v].change_val, vecs[v].pulse_at);
            @(negedge sclk);
            check_idle($sformatf("vec%0d after", v), 1'b1);
            for (int i = 0; i < 5; i++) begin
                @(negedge sclk);
                check_idle($sformatf("vec%0d quiet c%0d", v, i), 1'b1);
            end
        end

        // Back-to-back 0x00 then 0xFF with tx_valid held across the done cycle
        start_frame(8'h00);
        tx_data = 8'hFF;
        check_frame("b2b f1", 10'b1_00000000_0, 1'b1, -1, 8'h00, -10);
        @(negedge sclk);
        check_frame("b2b f2", 10'b1_11111111_0, 1'b0, -1, 8'h00, -10);
        @(negedge sclk);
        check_idle("b2b after", 1'b1);

        // Reset during data bit 3 of 0x55 (serial bit 4, line low)
        start_frame(8'h55);
        tx_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge sclk);
            check($sformatf("abort c%0d tx", i), 32'(tx), 32'(i / int'(BAUD) == 0 ? 1'b0 : ((8'h55 >> (i / int'(BAUD) - 1)) & 8'h01) != 0));
        end
        rst_n = 1'b0;
        #1;
        check_idle("abort async", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            check_idle($sformatf("abort rst c%0d", i), 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge sclk);
            check_idle($sformatf("abort post c%0d", i), 1'b1);
        end
        start_frame(8'h81);
        check_frame("post-abort 81", 10'b1_10000001_0, 1'b0, -1, 8'h00, -10);
        @(negedge sclk);
        check_idle("post-abort after", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
